// File: rtl/addsub_pipe_if.sv
// Handshake and data bundle for addsub_pipe.
//   Upstream side  : in_valid, in_ready, a, b, m (0 = add, 1 = subtract), sat (saturate on overflow)
//   Downstream side: out_valid, out_ready, s (result), c (carry out), v (signed overflow),
//                    z (result is zero)
// The master modport is the side that supplies operands and consumes results; the slave
// modport is the adder/subtractor itself.
interface addsub_pipe_if #(
  parameter int unsigned W = 32
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         m;
  logic         sat;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         c;
  logic         v;
  logic         z;

  modport master (
    output in_valid, a, b, m, sat, out_ready,
    input  in_ready, out_valid, s, c, v, z
  );

  modport slave (
    input  in_valid, a, b, m, sat, out_ready,
    output in_ready, out_valid, s, c, v, z
  );

endinterface

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor.
//
// The W-bit operation is cut into STAGES chunks of CW = W/STAGES bits. Stage k resolves chunk k
// with carry-lookahead and hands its carry-out, registered, to stage k+1. Operand chunks that are
// not resolved yet and result chunks that already are travel along in skew registers. A final
// output register holds s/c/v/z and out_valid.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset; discards everything in flight
//   bus    - addsub_pipe_if slave modport (valid/ready in, valid/ready out, operands, results)
//
// Parameters:
//   W      - operand/result width, must be a multiple of STAGES and >= 2
//   STAGES - pipeline depth and chunk count, >= 1; latency is STAGES cycles
//
// Flow control: the whole pipeline shares one advance enable, en = !out_valid || out_ready.
// Bubbles are kept as valid=0 entries so latency is always exactly STAGES enabled edges.
module addsub_pipe #(
  parameter int unsigned W      = 32,
  parameter int unsigned STAGES = 4
) (
  input logic         clk,
  input logic         rst_n,
  addsub_pipe_if.slave bus
);

  localparam int CW   = int'(W / STAGES);
  localparam int NS   = int'(STAGES);
  localparam int LAST = NS - 1;

  // Carry vector of one chunk in flattened lookahead form: carry into bit i+1 is the OR of every
  // generate at j <= i propagated through bits j+1..i, plus carry-in propagated through 0..i.
  // Bit 0 is the carry-in, bit CW is the chunk carry-out.
  function automatic logic [CW:0] lookahead(input logic [CW-1:0] x,
                                            input logic [CW-1:0] y,
                                            input logic          cin);
    logic [CW-1:0] g;
    logic [CW-1:0] p;
    logic [CW:0]   cy;
    logic          term;
    logic          acc;
    g     = x & y;
    p     = x ^ y;
    cy    = '0;
    cy[0] = cin;
    for (int i = 0; i < CW; i++) begin
      acc = 1'b0;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int l = j + 1; l <= i; l++) begin
          term = term & p[l];
        end
        acc = acc | term;
      end
      term = cin;
      for (int l = 0; l <= i; l++) begin
        term = term & p[l];
      end
      cy[i+1] = acc | term;
    end
    return cy;
  endfunction

  // Flow control
  logic en;
  logic accept;

  // Stage registers. b_q already holds b ^ {W{m}}; cy_q[0] holds m, the initial carry-in, so
  // every stage simply uses its own cy_q as carry-in.
  logic         vld_q [STAGES];
  logic [W-1:0] a_q   [STAGES];
  logic [W-1:0] b_q   [STAGES];
  logic [W-1:0] res_q [STAGES];
  logic         cy_q  [STAGES];
  logic         sat_q [STAGES];

  // Per-stage combinational results
  logic [W-1:0] res_nx  [STAGES];
  logic         cy_nx   [STAGES];
  logic         msb_cin [STAGES];
  logic [CW:0]  cv;

  // Final-stage results before the output register
  logic [W-1:0] s_raw;
  logic [W-1:0] s_fin;
  logic         c_raw;
  logic         v_raw;
  logic         z_fin;

  // Output register
  logic         out_valid_q;
  logic [W-1:0] s_q;
  logic         c_q;
  logic         v_q;
  logic         z_q;

  assign en           = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && en;
  assign bus.in_ready = en;

  // Resolve chunk k in stage k and merge it into the forwarded result word.
  always_comb begin
    cv = '0;
    for (int k = 0; k < NS; k++) begin
      cv         = lookahead(a_q[k][k*CW +: CW], b_q[k][k*CW +: CW], cy_q[k]);
      res_nx[k]  = res_q[k];
      res_nx[k][k*CW +: CW] = a_q[k][k*CW +: CW] ^ b_q[k][k*CW +: CW] ^ cv[CW-1:0];
      cy_nx[k]   = cv[CW];
      msb_cin[k] = cv[CW-1];
    end
  end

  // Flags and saturation. The overflow direction follows the sign of operand A, which is also
  // the sign of the mathematically correct result whenever overflow occurs.
  always_comb begin
    s_raw = res_nx[LAST];
    c_raw = cy_nx[LAST];
    v_raw = cy_nx[LAST] ^ msb_cin[LAST];
    s_fin = s_raw;
    if (sat_q[LAST] && v_raw) begin
      if (a_q[LAST][W-1]) begin
        s_fin = {1'b1, {(W-1){1'b0}}};
      end else begin
        s_fin = {1'b0, {(W-1){1'b1}}};
      end
    end
    z_fin = (s_fin == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NS; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
        cy_q[k]  <= 1'b0;
        sat_q[k] <= 1'b0;
      end
      out_valid_q <= 1'b0;
      s_q         <= '0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
    end else if (en) begin
      // Stage 0 always loads; without an accepted transaction it becomes a bubble.
      vld_q[0] <= accept;
      a_q[0]   <= bus.a;
      b_q[0]   <= bus.b ^ {W{bus.m}};
      res_q[0] <= '0;
      cy_q[0]  <= bus.m;
      sat_q[0] <= bus.sat;
      for (int k = 1; k < NS; k++) begin
        vld_q[k] <= vld_q[k-1];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
        res_q[k] <= res_nx[k-1];
        cy_q[k]  <= cy_nx[k-1];
        sat_q[k] <= sat_q[k-1];
      end
      out_valid_q <= vld_q[LAST];
      s_q         <= s_fin;
      c_q         <= c_raw;
      v_q         <= v_raw;
      z_q         <= z_fin;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.c         = c_q;
  assign bus.v         = v_q;
  assign bus.z         = z_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe. Three instances share one driver: sel 0 = W8/STAGES2,
// sel 1 = W32/STAGES4, sel 2 = W8/STAGES1. Directed vectors come from a table of constants;
// a random stream with random backpressure is checked against an arithmetic reference model.
module tb_addsub_pipe;

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        m;
    logic        sat;
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int          sel = 0;
  logic        in_valid = 1'b0;
  logic [31:0] a_d = '0;
  logic [31:0] b_d = '0;
  logic        m_d = 1'b0;
  logic        sat_d = 1'b0;
  logic        out_ready = 1'b1;

  logic        ov;
  logic        ir;
  logic [31:0] s_o;
  logic        c_o;
  logic        v_o;
  logic        z_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  addsub_pipe_if #(.W(8))  if0 ();
  addsub_pipe_if #(.W(32)) if1 ();
  addsub_pipe_if #(.W(8))  if2 ();

  assign if0.in_valid  = in_valid && (sel == 0);
  assign if0.a         = a_d[7:0];
  assign if0.b         = b_d[7:0];
  assign if0.m         = m_d;
  assign if0.sat       = sat_d;
  assign if0.out_ready = out_ready;

  assign if1.in_valid  = in_valid && (sel == 1);
  assign if1.a         = a_d;
  assign if1.b         = b_d;
  assign if1.m         = m_d;
  assign if1.sat       = sat_d;
  assign if1.out_ready = out_ready;

  assign if2.in_valid  = in_valid && (sel == 2);
  assign if2.a         = a_d[7:0];
  assign if2.b         = b_d[7:0];
  assign if2.m         = m_d;
  assign if2.sat       = sat_d;
  assign if2.out_ready = out_ready;

  addsub_pipe #(.W(8), .STAGES(2)) u_w8s2 (.clk(clk), .rst_n(rst_n), .bus(if0));
  addsub_pipe #(.W(32), .STAGES(4)) u_w32s4 (.clk(clk), .rst_n(rst_n), .bus(if1));
  addsub_pipe #(.W(8), .STAGES(1)) u_w8s1 (.clk(clk), .rst_n(rst_n), .bus(if2));

  always_comb begin
    ov  = 1'b0;
    ir  = 1'b0;
    s_o = '0;
    c_o = 1'b0;
    v_o = 1'b0;
    z_o = 1'b0;
    case (sel)
      0: begin
        ov = if0.out_valid; ir = if0.in_ready; s_o = {24'h0, if0.s};
        c_o = if0.c; v_o = if0.v; z_o = if0.z;
      end
      1: begin
        ov = if1.out_valid; ir = if1.in_ready; s_o = if1.s;
        c_o = if1.c; v_o = if1.v; z_o = if1.z;
      end
      default: begin
        ov = if2.out_valid; ir = if2.in_ready; s_o = {24'h0, if2.s};
        c_o = if2.c; v_o = if2.v; z_o = if2.z;
      end
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain (w+1)-bit arithmetic, overflow from operand/result signs.
  function automatic res_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                 input logic m, input logic sat);
    logic [63:0] mask;
    logic [63:0] yy;
    logic [63:0] full;
    logic        sx;
    logic        sy;
    logic        ss;
    res_t        r;
    mask = (64'd1 << w) - 64'd1;
    yy   = m ? (~y & mask) : y;
    full = x + yy + {63'd0, m};
    r.s  = 32'(full & mask);
    r.c  = full[w];
    sx   = x[w-1];
    sy   = y[w-1];
    ss   = full[w-1];
    r.v  = m ? ((sx != sy) && (ss != sx)) : ((sx == sy) && (ss != sx));
    if (sat && r.v) r.s = sx ? 32'(64'd1 << (w - 1)) : 32'(mask >> 1);
    r.z = (r.s == 32'd0);
    return r;
  endfunction

  // One isolated transaction with out_ready=1; checks latency and all result fields.
  task automatic run_vec(input vec_t t, input string name);
    int   n;
    logic got;
    @(negedge clk);
    sel = t.sel; a_d = t.a; b_d = t.b; m_d = t.m; sat_d = t.sat; in_valid = 1'b1;
    #1;
    check({name, "_in_ready"}, 64'(ir), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      got = ov;
    end
    check({name, "_out_valid"}, 64'(got), 64'd1);
    check({name, "_latency"}, 64'(n), 64'(t.lat));
    check({name, "_s"}, 64'(s_o), 64'(t.s));
    check({name, "_cvz"}, 64'({c_o, v_o, z_o}), 64'({t.c, t.v, t.z}));
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_out_valid"}, 64'(ov), 64'd0);
    check({name, "_s"}, 64'(s_o), 64'd0);
    check({name, "_cvz"}, 64'({c_o, v_o, z_o}), 64'd0);
  endtask

  initial begin
    vec_t vecs[$];
    vec_t tv;
    res_t q[$];
    res_t exp_r;
    int   sent;
    int   recv;
    int   cyc;
    logic acc;
    logic cons;

    //            sel  a             b             m     sat   s             c     v     z    lat
    vecs.push_back('{0, 32'h7F,       32'h01,       1'b0, 1'b0, 32'h80,       1'b0, 1'b1, 1'b0, 2});
    vecs.push_back('{0, 32'h7F,       32'h01,       1'b0, 1'b1, 32'h7F,       1'b0, 1'b1, 1'b0, 2});
    vecs.push_back('{0, 32'h80,       32'h01,       1'b1, 1'b1, 32'h80,       1'b1, 1'b1, 1'b0, 2});
    vecs.push_back('{0, 32'h05,       32'h05,       1'b1, 1'b0, 32'h00,       1'b1, 1'b0, 1'b1, 2});
    vecs.push_back('{1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 4});
    vecs.push_back('{1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 4});
    vecs.push_back('{1, 32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 4});
    vecs.push_back('{1, 32'h00010000, 32'h00000001, 1'b1, 1'b0, 32'h0000FFFF, 1'b1, 1'b0, 1'b0, 4});
    vecs.push_back('{1, 32'h12345678, 32'h0FEDCBA8, 1'b0, 1'b0, 32'h22222220, 1'b0, 1'b0, 1'b0, 4});
    vecs.push_back('{1, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0, 4});
    vecs.push_back('{2, 32'h10,       32'h20,       1'b0, 1'b0, 32'h30,       1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{2, 32'hF0,       32'h10,       1'b1, 1'b0, 32'hE0,       1'b1, 1'b0, 1'b0, 1});

    // Reset state, every instance.
    #3;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check_idle_outputs($sformatf("reset%0d", i));
      check($sformatf("reset%0d_in_ready", i), 64'(ir), 64'd1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // STAGES=1 back-to-back: results on consecutive cycles.
    @(negedge clk);
    sel = 2; a_d = 32'h10; b_d = 32'h20; m_d = 1'b0; sat_d = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 a_d = 32'hF0; b_d = 32'h10; m_d = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("b2b_first_valid", 64'(ov), 64'd1);
    check("b2b_first_s", 64'(s_o), 64'h30);
    check("b2b_first_c", 64'(c_o), 64'd0);
    @(negedge clk);
    check("b2b_second_valid", 64'(ov), 64'd1);
    check("b2b_second_s", 64'(s_o), 64'hE0);
    check("b2b_second_c", 64'(c_o), 64'd1);
    @(negedge clk);
    check("b2b_drain_valid", 64'(ov), 64'd0);

    // Random stream under random backpressure on the 32-bit instance.
    sel  = 1;
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 16 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 16 && !in_valid) begin
        a_d = $urandom; b_d = $urandom;
        m_d = 1'($urandom_range(0, 1)); sat_d = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      #1;
      if (ov) begin
        if (q.size() == 0) begin
          check("stream_extra_result", 64'(ov), 64'd0);
        end else begin
          check("stream_s", 64'(s_o), 64'(q[0].s));
          check("stream_cvz", 64'({c_o, v_o, z_o}), 64'({q[0].c, q[0].v, q[0].z}));
        end
      end
      acc  = in_valid && ir;
      cons = ov && out_ready;
      if (acc) exp_r = model(32, {32'h0, a_d}, {32'h0, b_d}, m_d, sat_d);
      @(posedge clk);
      #1;
      if (cons && q.size() > 0) begin
        void'(q.pop_front());
        recv++;
      end
      if (acc) begin
        q.push_back(exp_r);
        sent++;
        in_valid = 1'b0;
      end
    end
    check("stream_received", 64'(recv), 64'd16);
    out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("stream_no_duplicate", 64'(ov), 64'd0);
    end
    check("stream_queue_empty", 64'(q.size()), 64'd0);

    // Reset with three transactions in flight.
    @(negedge clk);
    sel = 1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_d = $urandom; b_d = $urandom; m_d = 1'b0; sat_d = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    check("midreset_in_ready", 64'(ir), 64'd1);
    repeat (2) begin
      @(negedge clk);
      check_idle_outputs("midreset_hold");
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("postreset_no_stale", 64'(ov), 64'd0);
    end
    tv = '{1, 32'h00000002, 32'h00000003, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 4};
    run_vec(tv, "postreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Pipelined, parametrised two's-complement adder/subtractor with a valid/ready handshake on both sides. The W-bit operation is split into STAGES equal chunks. Each chunk is resolved in its own pipeline stage with carry-lookahead inside the chunk, and the chunk carry is registered into the next stage. Per-transaction add/sub select, optional signed saturation and C/V/Z flags are provided. The block replaces the single-cycle combinational add/sub on datapaths whose width no longer closes timing in one cycle.

## Interface
- W, 32, operand/result width; must be a multiple of STAGES, and W >= 2.
- STAGES, 4, pipeline depth and chunk count; chunk width CW = W/STAGES; STAGES >= 1.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand transaction present.
- in_ready  out  1  block accepts a transaction this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- m  in  1  mode: 0 = A+B, 1 = A-B.
- sat  in  1  1 = saturate the signed result on overflow.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- s  out  W  result.
- c  out  1  raw carry out of bit W-1. For subtract, 1 = no borrow.
- v  out  1  signed overflow.
- z  out  1  s == 0, evaluated after saturation.

## Operation
- Global advance enable: en = !out_valid || out_ready. in_ready = en, combinationally.
- A transaction is accepted when in_valid && in_ready. On acceptance, stage 0 captures a, b^{W{m}}, m, sat and valid=1.
- Bubbles are carried as valid=0 entries and are not collapsed. When en=1 and no transaction is accepted, stage 0 loads valid=0.
- Stage k (0..STAGES-1):
  - Computes chunk bits [k*CW +: CW] as a^b'^carry, using generate/propagate lookahead within the chunk.
  - Carry-in is m for k=0, else the registered carry from stage k-1.
  - Result chunks already computed are forwarded unchanged. Operand chunks not yet computed are forwarded (skew registers).
- Final-stage flags:
  - c = carry out of bit W-1.
  - v = carry into bit W-1 XOR carry out of bit W-1.
- Saturation: if sat=1 and v=1:
  - s = {1'b0, {W-1{1'b1}}} when a[W-1]=0 (positive overflow).
  - s = {1'b1, {W-1{1'b0}}} otherwise.
  - c and v keep their raw values.
- z is computed on the final s.
- The output register holds s, c, v, z and out_valid. These values are stable while out_valid && !out_ready.
- Every pipeline register updates only when en=1. When en=0 the whole pipeline freezes, including bubble entries.

## Timing
- Reset (rst_n low, asynchronous):
  - All valid bits clear; all data and flag registers clear.
  - Outputs: out_valid=0, s=0, c=0, v=0, z=0.
  - in_ready=1 as soon as reset asserts, because out_valid=0.
- Reset mid-operation discards all in-flight transactions. No output is produced for them.
- Latency: a transaction accepted at edge t drives out_valid=1 after edge t+STAGES, provided en=1 on every intervening edge. Each edge with en=0 adds one cycle.
- Throughput: one transaction per cycle while out_ready=1.
- STAGES=1 gives a single registered stage with latency 1.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0. No accepted transaction is dropped or duplicated.
- Simultaneous events: when out_valid && out_ready && in_valid occur in the same cycle, the output is consumed and the new input is accepted on the same edge.
- Wrap-around:
  - Unsigned results are modulo 2^W. Example: 0xFFFFFFFF + 1 gives s=0, c=1, z=1.
  - With sat=0, signed overflow wraps and sets v=1.

## Test plan
- W=8, STAGES=2, out_ready=1. Send 0x7F+0x01 with sat=0, then the same with sat=1.
  - Required: s=0x80, v=1, c=0, then s=0x7F, v=1.
  - Each result appears 2 cycles after acceptance.
- W=8, STAGES=2. Send 0x80-0x01 with sat=1, then 0x05-0x05.
  - Required: first s=0x80 (saturated low), v=1, c=1.
  - Then s=0x00, z=1, c=1, v=0.
- Defaults. Send 0xFFFFFFFF+0x00000001.
  - Required: s=0, c=1, v=0, z=1, out_valid exactly 4 cycles after acceptance.
  - This checks the carry ripple across all chunk boundaries.
- Defaults. Stream 16 random back-to-back transactions while toggling out_ready pseudo-randomly.
  - Required: results match a reference model in order, none lost or duplicated.
  - s, c, v and z are held stable whenever out_ready=0.
- Defaults. Assert rst_n low with 3 transactions in flight, then release and send 0x00000002-0x00000003.
  - Required: out_valid=0 and all outputs 0 during reset, and no stale results afterwards.
  - Next result is s=0xFFFFFFFF, c=0, v=0.
- W=8, STAGES=1. Send back-to-back 0x10+0x20 and 0xF0-0x10.
  - Required: s=0x30, then s=0xE0 with c=1, each one cycle after acceptance.
